// File: rtl/mul_result_merge_pkg.sv
// Shared result-uop and branch-provider types plus the branch kill rule
// used by the ALU, multiplier and writeback merge logic.
package mul_result_merge_pkg;

  localparam int unsigned SQN_W    = 7;
  localparam int unsigned UOP_W    = 88;
  localparam int unsigned BRANCH_W = 76;

  typedef struct packed {
    logic [31:0]       result;
    logic [6:0]        tag_dst;
    logic [4:0]        nm_dst;
    logic [SQN_W-1:0]  sqn;
    logic [31:0]       pc;
    logic [2:0]        flags;
    logic              compressed;
    logic              valid;
  } res_uop_t;

  typedef struct packed {
    logic [31:0]       rsv_hi;
    logic [SQN_W-1:0]  sqn;
    logic [35:0]       rsv_lo;
    logic              valid;
  } branch_prov_t;

  // A uop is killed when it is strictly younger than a mispredicting branch.
  function automatic logic is_killed(input logic [SQN_W-1:0] sqn, input branch_prov_t br);
    logic [SQN_W-1:0] diff;
    diff = sqn - br.sqn;
    return br.valid && !diff[SQN_W-1] && (diff != '0);
  endfunction

endpackage

// File: rtl/mul_result_merge_result_fifo.sv
// In-order holding FIFO for multiplier results that lost writeback arbitration,
// with per-entry valid bits cleared by branch flushes.
module result_fifo
  import mul_result_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  res_uop_t                     push_uop_i,
  input  logic                         pop_i,
  input  branch_prov_t                 branch_i,
  output res_uop_t                     head_uop_c,
  output logic                         head_live_c,
  output logic                         empty_c,
  output logic                         full_c,
  output logic                         push_ok_c,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  res_uop_t           mem_q [DEPTH];
  res_uop_t           mem_d [DEPTH];
  logic [DEPTH-1:0]   ev_q, ev_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop_ok;
  logic               unused_br_c;

  assign unused_br_c = ^{branch_i.rsv_hi, branch_i.rsv_lo};
  assign count_o     = count_q;

  // Flush-clear first, then pop, then push so a full-FIFO push/pop keeps the new entry live.
  always_comb begin
    empty_c     = (count_q == '0);
    full_c      = (count_q == CNT_W'(DEPTH));
    pop_ok      = pop_i && !empty_c;
    push_ok_c   = push_i && (!full_c || pop_ok);
    head_uop_c  = mem_q[head_q];
    head_live_c = !empty_c && ev_q[head_q] && !is_killed(mem_q[head_q].sqn, branch_i);
    mem_d       = mem_q;
    ev_d        = ev_q;
    head_d      = head_q;
    tail_d      = tail_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (is_killed(mem_q[i].sqn, branch_i)) ev_d[i] = 1'b0;
    end
    if (pop_ok) begin
      ev_d[head_q] = 1'b0;
      head_d       = PTR_W'(head_q + 1'b1);
    end
    if (push_ok_c) begin
      mem_d[tail_q] = push_uop_i;
      ev_d[tail_q]  = 1'b1;
      tail_d        = PTR_W'(tail_q + 1'b1);
    end
    count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ev_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      ev_q    <= ev_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_result_merge.sv
// Writeback merge: ALU has fixed priority, multiplier results bypass or queue
// in order behind it; early busy throttles multiplier issue.
module mul_result_merge
  import mul_result_merge_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned INFLIGHT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BRANCH_W-1:0]  IN_branch,
  input  logic [UOP_W-1:0]     IN_aluUop,
  input  logic [UOP_W-1:0]     IN_mulUop,
  output logic [UOP_W-1:0]     OUT_uop,
  output logic                 OUT_mulBusy,
  output logic                 OUT_overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  branch_prov_t      br;
  res_uop_t          alu, mul, head_uop, uop_d, uop_q;
  logic              head_live, fifo_empty, fifo_full, push_ok;
  logic              alu_live, mul_live, bypass, push, pop;
  logic              overflow_d, overflow_q;
  logic [CNT_W-1:0]  count;
  logic              unused_br_c;

  assign br          = branch_prov_t'(IN_branch);
  assign alu         = res_uop_t'(IN_aluUop);
  assign mul         = res_uop_t'(IN_mulUop);
  assign unused_br_c = ^{br.rsv_hi, br.rsv_lo, push_ok};

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_uop_i  (mul),
    .pop_i       (pop),
    .branch_i    (br),
    .head_uop_c  (head_uop),
    .head_live_c (head_live),
    .empty_c     (fifo_empty),
    .full_c      (fifo_full),
    .push_ok_c   (push_ok),
    .count_o     (count)
  );

  // Source select: ALU, then live FIFO head, then bypass only when the FIFO is empty.
  always_comb begin
    uop_d      = '0;
    bypass     = 1'b0;
    overflow_d = overflow_q;
    alu_live   = alu.valid && !is_killed(alu.sqn, br);
    mul_live   = mul.valid && !is_killed(mul.sqn, br);

    if (alu_live) begin
      uop_d = alu;
    end else if (head_live) begin
      uop_d = head_uop;
    end else if (fifo_empty && mul_live) begin
      uop_d  = mul;
      bypass = 1'b1;
    end

    // Dead heads drain every cycle; a live head leaves only when the ALU is quiet.
    pop  = !fifo_empty && (!head_live || !alu_live);
    push = mul_live && !bypass;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uop_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      uop_q      <= uop_d;
      overflow_q <= overflow_d;
    end
  end

  assign OUT_uop      = uop_q;
  assign OUT_overflow = overflow_q;
  assign OUT_mulBusy  = (32'(count) + INFLIGHT) >= DEPTH;

endmodule

// File: tb/tb_mul_result_merge.sv
// Scoreboard bench for mul_result_merge: directed vectors push expected uops,
// a negedge monitor pops and compares every valid OUT_uop.
module tb_mul_result_merge;
  import mul_result_merge_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [BRANCH_W-1:0] in_branch = '0;
  logic [UOP_W-1:0]    in_alu = '0;
  logic [UOP_W-1:0]    in_mul = '0;
  logic [UOP_W-1:0]    out_uop;
  logic                out_busy, out_ovf;

  int checks = 0;
  int errors = 0;
  logic [UOP_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mul_result_merge #(.DEPTH(8), .INFLIGHT(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_branch    (in_branch),
    .IN_aluUop    (in_alu),
    .IN_mulUop    (in_mul),
    .OUT_uop      (out_uop),
    .OUT_mulBusy  (out_busy),
    .OUT_overflow (out_ovf)
  );

  function automatic logic [UOP_W-1:0] mk(input logic [6:0] sqn, input logic [31:0] res);
    res_uop_t u;
    u         = '0;
    u.result  = res;
    u.tag_dst = sqn;
    u.nm_dst  = sqn[4:0];
    u.sqn     = sqn;
    u.pc      = 32'h0000_4000 + {25'd0, sqn};
    u.flags   = 3'b010;
    u.valid   = 1'b1;
    return u;
  endfunction

  function automatic logic [BRANCH_W-1:0] brn(input logic [6:0] s);
    branch_prov_t b;
    b        = '0;
    b.valid  = 1'b1;
    b.sqn    = s;
    b.rsv_hi = 32'hdead_beef;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic cyc(input logic [UOP_W-1:0] a, input logic [UOP_W-1:0] m,
                     input logic [BRANCH_W-1:0] b);
    in_alu    = a;
    in_mul    = m;
    in_branch = b;
    @(posedge clk);
    #1;
    in_alu    = '0;
    in_mul    = '0;
    in_branch = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, '0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc('0, '0, '0);
    chk({"drain_", name}, 32'(exp_q.size()), 32'd0);
    idle(3);
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_fifo.count_q);
  endfunction

  // Monitor: every valid output must match the oldest expected uop.
  always @(negedge clk) begin
    if (!rst && out_uop[0]) begin
      logic [UOP_W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got sqn %0d result %0h expected no output",
                 out_uop[43:37], out_uop[87:56]);
      end else begin
        e = exp_q.pop_front();
        if (out_uop !== e) begin
          errors++;
          $display("FAIL sb_data: got sqn %0d result %0h uop %h expected sqn %0d result %0h uop %h",
                   out_uop[43:37], out_uop[87:56], out_uop, e[43:37], e[87:56], e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_uop_zero", 32'(out_uop != '0), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_count", cnt(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bypass
    exp_q.push_back(mk(7'd5, 32'h0000_0006));
    cyc('0, mk(7'd5, 32'h0000_0006), '0);
    chk("byp_valid", 32'(out_uop[0]), 32'd1);
    chk("byp_result", out_uop[87:56], 32'h6);
    chk("byp_count", cnt(), 32'd0);
    drain("bypass");

    // Contention: ALU wins three cycles, mul results follow in order
    exp_q.push_back(mk(7'd1, 32'hA1));
    exp_q.push_back(mk(7'd2, 32'hA2));
    exp_q.push_back(mk(7'd3, 32'hA3));
    exp_q.push_back(mk(7'd10, 32'd100));
    exp_q.push_back(mk(7'd11, 32'd110));
    exp_q.push_back(mk(7'd12, 32'd120));
    cyc(mk(7'd1, 32'hA1), mk(7'd10, 32'd100), '0);
    chk("cont_cnt1", cnt(), 32'd1);
    chk("cont_busy1", 32'(out_busy), 32'd0);
    cyc(mk(7'd2, 32'hA2), mk(7'd11, 32'd110), '0);
    chk("cont_cnt2", cnt(), 32'd2);
    chk("cont_busy2", 32'(out_busy), 32'd1);
    cyc(mk(7'd3, 32'hA3), mk(7'd12, 32'd120), '0);
    chk("cont_cnt3", cnt(), 32'd3);
    chk("cont_busy3", 32'(out_busy), 32'd1);
    idle(1);
    chk("cont_cnt4", cnt(), 32'd2);
    chk("cont_busy4", 32'(out_busy), 32'd1);
    idle(1);
    chk("cont_cnt5", cnt(), 32'd1);
    chk("cont_busy5", 32'(out_busy), 32'd0);
    drain("contention");
    chk("cont_cnt_end", cnt(), 32'd0);

    // Flush inside FIFO: branch sqN 20 kills stored 21 and 22
    exp_q.push_back(mk(7'd16, 32'hB16));
    exp_q.push_back(mk(7'd17, 32'hB17));
    exp_q.push_back(mk(7'd18, 32'hB18));
    exp_q.push_back(mk(7'd19, 32'hB19));
    exp_q.push_back(mk(7'd20, 32'd200));
    cyc(mk(7'd16, 32'hB16), mk(7'd20, 32'd200), '0);
    cyc(mk(7'd17, 32'hB17), mk(7'd21, 32'd210), '0);
    cyc(mk(7'd18, 32'hB18), mk(7'd22, 32'd220), '0);
    cyc(mk(7'd19, 32'hB19), '0, brn(7'd20));
    chk("flush_cnt_held", cnt(), 32'd3);
    idle(3);
    chk("flush_cnt_end", cnt(), 32'd0);
    drain("flush");

    // Kill at input
    cyc('0, mk(7'd40, 32'd400), brn(7'd38));
    chk("kill_cnt", cnt(), 32'd0);
    chk("kill_no_out", 32'(out_uop[0]), 32'd0);
    idle(2);
    exp_q.push_back(mk(7'd37, 32'hC37));
    cyc(mk(7'd37, 32'hC37), mk(7'd40, 32'd400), brn(7'd38));
    chk("kill_alu_cnt", cnt(), 32'd0);
    drain("kill");

    // Overflow: eight stored entries, ninth dropped
    for (int i = 0; i < 9; i++) exp_q.push_back(mk(7'(100 + i), 32'hD00 + 32'(i)));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(7'(50 + i), 32'hE00 + 32'(i)));
    for (int i = 0; i < 8; i++) cyc(mk(7'(100 + i), 32'hD00 + 32'(i)), mk(7'(50 + i), 32'hE00 + 32'(i)), '0);
    chk("ovf_cnt_full", cnt(), 32'd8);
    chk("ovf_busy_full", 32'(out_busy), 32'd1);
    chk("ovf_pre", 32'(out_ovf), 32'd0);
    cyc(mk(7'd108, 32'hD08), mk(7'd58, 32'hE08), '0);
    chk("ovf_cnt_after", cnt(), 32'd8);
    chk("ovf_set", 32'(out_ovf), 32'd1);
    drain("overflow");
    chk("ovf_sticky", 32'(out_ovf), 32'd1);
    chk("ovf_cnt_end", cnt(), 32'd0);

    // Async reset mid-run with four stored entries
    exp_q.push_back(mk(7'd90, 32'hF90));
    exp_q.push_back(mk(7'd91, 32'hF91));
    exp_q.push_back(mk(7'd92, 32'hF92));
    for (int i = 0; i < 4; i++) cyc(mk(7'(90 + i), 32'hF90 + 32'(i)), mk(7'(70 + i), 32'd700 + 32'(i)), '0);
    chk("arst_pre_cnt", cnt(), 32'd4);
    chk("arst_pre_valid", 32'(out_uop[0]), 32'd1);
    chk("arst_pre_busy", 32'(out_busy), 32'd1);
    chk("arst_pre_sb", 32'(exp_q.size()), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_uop_zero", 32'(out_uop != '0), 32'd0);
    chk("arst_cnt", cnt(), 32'd0);
    chk("arst_ovf", 32'(out_ovf), 32'd0);
    chk("arst_busy", 32'(out_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(7'd80, 32'h1234));
    cyc('0, mk(7'd80, 32'h1234), '0);
    chk("arst_byp_valid", 32'(out_uop[0]), 32'd1);
    chk("arst_byp_result", out_uop[87:56], 32'h1234);
    drain("after_reset");
    chk("arst_cnt_end", cnt(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
